// File: rtl/rf_write_arbiter.sv
// Write-port owner for the 32x32 register file: round-robin arbitration between the ALU (A)
// and load (B) writeback requesters, plus a zero-fill clear sweep after reset or on request.

module rf_write_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int NUM_REGS       = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              clear_req,
  output logic              busy,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  // cnt carries one extra bit so a full 2**ADDR_W sweep can be counted without wrapping
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  state_t            state_r;
  logic [ADDR_W:0]   cnt_r;
  logic              rr_ptr_r;
  logic              grant_a_s;
  logic              grant_b_s;

  // Grant selection: only in RUN and never in the cycle a clear is requested
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if ((state_r == ST_RUN) && !clear_req) begin
      if (a_valid && b_valid) begin
        if (rr_ptr_r == PTR_A) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else begin
        grant_a_s = a_valid;
        grant_b_s = b_valid;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // FSM, round-robin pointer and registered register-file write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      busy           <= CLEAR_ON_RESET;
      cnt_r          <= {(ADDR_W + 1){1'b0}};
      rr_ptr_r       <= PTR_A;
      reg_write      <= 1'b0;
      write_register <= {ADDR_W{1'b0}};
      write_data     <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          reg_write      <= 1'b1;
          write_register <= cnt_r[ADDR_W-1:0];
          write_data     <= {DATA_W{1'b0}};
          if (cnt_r == LAST_CNT) begin
            state_r <= ST_RUN;
            busy    <= 1'b0;
            cnt_r   <= {(ADDR_W + 1){1'b0}};
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            state_r   <= ST_CLEAR;
            busy      <= 1'b1;
            cnt_r     <= {(ADDR_W + 1){1'b0}};
            reg_write <= 1'b0;
          end else if (grant_a_s) begin
            reg_write      <= 1'b1;
            write_register <= a_addr;
            write_data     <= a_data;
            rr_ptr_r       <= PTR_B;
          end else if (grant_b_s) begin
            reg_write      <= 1'b1;
            write_register <= b_addr;
            write_data     <= b_data;
            rr_ptr_r       <= PTR_A;
          end else begin
            // Idle: address and data hold so the file sees a stable bus
            reg_write <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_RUN;
          busy      <= 1'b0;
          cnt_r     <= {(ADDR_W + 1){1'b0}};
          reg_write <= 1'b0;
        end
      endcase
    end
  end

  rf_write_arbiter_checker u_checker (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .busy    (busy)
  );

endmodule

// Handshake invariants of the arbiter, kept apart from the datapath.
module rf_write_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic a_valid,
  input logic a_ready,
  input logic b_valid,
  input logic b_ready,
  input logic busy
);

  a_one_grant: assert property (@(posedge clk) disable iff (rst) !(a_ready && b_ready));
  a_ready_needs_valid: assert property (@(posedge clk) disable iff (rst) a_ready |-> a_valid);
  b_ready_needs_valid: assert property (@(posedge clk) disable iff (rst) b_ready |-> b_valid);
  no_grant_when_busy: assert property (@(posedge clk) disable iff (rst) busy |-> !(a_ready || b_ready));

endmodule
